// File: rtl/ball_motion.sv
// Ball position/direction engine for a breakout-style game: tracks the paddle while
// idle, steps the ball once per motion tick and reflects it off walls, paddle and bricks.
module ball_motion #(
    parameter int TICK_DIV   = 1000000,
    parameter int STEP       = 2,
    parameter int BALL_SIZE  = 8,
    parameter int SCREEN_W   = 640,
    parameter int SCREEN_H   = 480,
    parameter int PADDLE_W   = 64,
    parameter int LOST_TICKS = 50
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       launch,
    input  logic       pause,
    input  logic [9:0] paddle_x,
    input  logic [9:0] paddle_y,
    input  logic       brick_hit,
    output logic [9:0] ball_x,
    output logic [9:0] ball_y,
    output logic       dir_x,
    output logic       dir_y,
    output logic       paddle_hit,
    output logic       miss,
    output logic [1:0] state
);

    localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int LW = (LOST_TICKS > 1) ? $clog2(LOST_TICKS) : 1;

    // All geometry is done in 11 bits so sums near the screen edge cannot wrap.
    localparam logic [10:0] STEP_W  = 11'(STEP);
    localparam logic [10:0] BALL_W  = 11'(BALL_SIZE);
    localparam logic [10:0] SCR_W   = 11'(SCREEN_W);
    localparam logic [10:0] SCR_H   = 11'(SCREEN_H);
    localparam logic [10:0] PAD_W   = 11'(PADDLE_W);
    localparam logic [10:0] TRACK_X = 11'(PADDLE_W / 2 - BALL_SIZE / 2);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        MOVING = 2'd1,
        PAUSED = 2'd2,
        LOST   = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic [TW-1:0] tick_cnt;
    logic [LW-1:0] lost_cnt, lost_d;
    logic        tick, launch_q, launch_rise;
    logic        pending, pend_d;
    logic [9:0]  x_d, y_d;
    logic        dx_d, dy_d, hit_d, miss_d;
    logic [10:0] bx, by, px, py;
    logic        dy_eff, contact;

    assign state       = state_q;
    assign tick        = (tick_cnt == TW'(TICK_DIV - 1));
    assign launch_rise = launch & ~launch_q;
    assign bx          = {1'b0, ball_x};
    assign by          = {1'b0, ball_y};
    assign px          = {1'b0, paddle_x};
    assign py          = {1'b0, paddle_y};
    assign dy_eff      = dir_y ^ pending;

    // Paddle contact looks at the direction before the brick flip so it wins over a brick.
    assign contact = dir_y && (by + BALL_W <= py) && (by + BALL_W + STEP_W >= py)
                     && (bx + BALL_W > px) && (bx < px + PAD_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tick_cnt <= '0;
            launch_q <= 1'b0;
        end else begin
            tick_cnt <= tick ? '0 : tick_cnt + TW'(1);
            launch_q <= launch;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            ball_x     <= '0;
            ball_y     <= '0;
            dir_x      <= 1'b1;
            dir_y      <= 1'b0;
            paddle_hit <= 1'b0;
            miss       <= 1'b0;
            pending    <= 1'b0;
            lost_cnt   <= '0;
        end else begin
            state_q    <= state_d;
            ball_x     <= x_d;
            ball_y     <= y_d;
            dir_x      <= dx_d;
            dir_y      <= dy_d;
            paddle_hit <= hit_d;
            miss       <= miss_d;
            pending    <= pend_d;
            lost_cnt   <= lost_d;
        end
    end

    always_comb begin
        state_d = state_q;
        x_d     = ball_x;
        y_d     = ball_y;
        dx_d    = dir_x;
        dy_d    = dir_y;
        pend_d  = pending;
        lost_d  = lost_cnt;
        hit_d   = 1'b0;
        miss_d  = 1'b0;
        case (state_q)
            IDLE: begin
                x_d    = 10'(px + TRACK_X);
                y_d    = 10'(py - BALL_W);
                dx_d   = 1'b1;
                dy_d   = 1'b0;
                pend_d = 1'b0;
                lost_d = '0;
                if (launch_rise) state_d = MOVING;
            end
            MOVING: begin
                if (brick_hit) pend_d = 1'b1;
                if (pause) begin
                    state_d = PAUSED;
                end else if (tick) begin
                    // A brick pulse arriving on the tick cycle is kept for the next tick.
                    pend_d = brick_hit;
                    if (!dir_x) begin
                        if (bx < STEP_W) begin
                            x_d  = '0;
                            dx_d = 1'b1;
                        end else begin
                            x_d = 10'(bx - STEP_W);
                        end
                    end else if (bx + BALL_W + STEP_W > SCR_W) begin
                        x_d  = 10'(SCR_W - BALL_W);
                        dx_d = 1'b0;
                    end else begin
                        x_d = 10'(bx + STEP_W);
                    end
                    if (contact) begin
                        y_d   = 10'(py - BALL_W);
                        dy_d  = 1'b0;
                        hit_d = 1'b1;
                    end else if (!dy_eff) begin
                        if (by < STEP_W) begin
                            y_d  = '0;
                            dy_d = 1'b1;
                        end else begin
                            y_d  = 10'(by - STEP_W);
                            dy_d = 1'b0;
                        end
                    end else if (by + BALL_W + STEP_W >= SCR_H) begin
                        y_d     = 10'(SCR_H - BALL_W);
                        dy_d    = 1'b1;
                        miss_d  = 1'b1;
                        state_d = LOST;
                    end else begin
                        y_d  = 10'(by + STEP_W);
                        dy_d = 1'b1;
                    end
                end
            end
            PAUSED: begin
                if (brick_hit) pend_d = 1'b1;
                if (!pause) state_d = MOVING;
            end
            LOST: begin
                if (tick) begin
                    if (lost_cnt == LW'(LOST_TICKS - 1)) begin
                        lost_d  = '0;
                        state_d = IDLE;
                    end else begin
                        lost_d = lost_cnt + LW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule
